phase_pair_gen: RTL and testbench



---
 rtl/phase_pair_gen.sv | 148 ++++++++++++++
 tb/tb_phase_pair_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_pair_gen.sv
// Phase-pair feeder for the pipelined phase interpolator: an NCO position accumulator
// decides whether to repeat the current sample pair or consume new samples. Optional macro: PHASE_PAIR_STAT_EN.
module phase_pair_gen #(
  parameter int PHASE_DW = 15,
  parameter int FBIT     = 8,
  parameter int STEP_IW  = 4,
  parameter int PASS_DW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [STEP_IW+FBIT-1:0] step,
  input  logic [PHASE_DW-1:0]     in_phase,
  input  logic [PASS_DW-1:0]      in_pass,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PHASE_DW-1:0]     phase1,
  output logic [PHASE_DW-1:0]     phase2,
  output logic [FBIT-1:0]         phase_frac,
  output logic [PASS_DW-1:0]      phase_pass_data,
  output logic                    phase_valid,
  input  logic                    phase_ready
`ifdef PHASE_PAIR_STAT_EN
  ,
  output logic [31:0]             stat_in_cnt,
  output logic [31:0]             stat_out_cnt
`endif
);

  localparam int ACC_W  = STEP_IW + FBIT + 1;
  localparam int SKIP_W = STEP_IW + 1;
  localparam logic [ACC_W-1:0] ONE_C = ACC_W'(1) << FBIT;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [PHASE_DW-1:0] s0_r, s1_r, s0_nxt_s, s1_nxt_s;
  logic [PASS_DW-1:0]  p1_r, p1_nxt_s;
  logic [ACC_W-1:0]    acc_r, acc_nxt_s;
  logic [SKIP_W-1:0]   skip_s;
  logic                in_fire_s, out_fire_s;

  // skip counts whole samples the accumulator has run ahead of the current pair
  assign skip_s      = acc_r[ACC_W-1:FBIT];
  assign in_ready    = (state_r != ST_RUN) || (skip_s != {SKIP_W{1'b0}});
  assign phase_valid = (state_r == ST_RUN) && (skip_s == {SKIP_W{1'b0}});
  assign in_fire_s   = in_valid & in_ready;
  assign out_fire_s  = phase_valid & phase_ready;

  assign phase1          = s0_r;
  assign phase2          = s1_r;
  assign phase_frac      = acc_r[FBIT-1:0];
  assign phase_pass_data = p1_r;

  // Next-state and datapath update; flush overrides any fire in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    s0_nxt_s    = s0_r;
    s1_nxt_s    = s1_r;
    p1_nxt_s    = p1_r;
    acc_nxt_s   = acc_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      acc_nxt_s   = {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            s1_nxt_s    = in_phase;
            p1_nxt_s    = in_pass;
            state_nxt_s = ST_HALF;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (in_fire_s) begin
            s0_nxt_s    = s1_r;
            s1_nxt_s    = in_phase;
            p1_nxt_s    = in_pass;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALF;
          end
        end
        ST_RUN: begin
          if (out_fire_s) begin
            acc_nxt_s = acc_r + {1'b0, step};
          end else if (in_fire_s) begin
            s0_nxt_s  = s1_r;
            s1_nxt_s  = in_phase;
            p1_nxt_s  = in_pass;
            acc_nxt_s = acc_r - ONE_C;
          end else begin
            acc_nxt_s = acc_r;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          acc_nxt_s   = {ACC_W{1'b0}};
        end
      endcase
    end
  end

  // State, sample pair and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      s0_r    <= {PHASE_DW{1'b0}};
      s1_r    <= {PHASE_DW{1'b0}};
      p1_r    <= {PASS_DW{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      s0_r    <= s0_nxt_s;
      s1_r    <= s1_nxt_s;
      p1_r    <= p1_nxt_s;
      acc_r   <= acc_nxt_s;
    end
  end

`ifdef PHASE_PAIR_STAT_EN
  logic [31:0] stat_in_r, stat_out_r;

  // Fire counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_r  <= 32'd0;
      stat_out_r <= 32'd0;
    end else if (flush) begin
      stat_in_r  <= 32'd0;
      stat_out_r <= 32'd0;
    end else begin
      stat_in_r  <= stat_in_r + {31'd0, in_fire_s};
      stat_out_r <= stat_out_r + {31'd0, out_fire_s};
    end
  end

  assign stat_in_cnt  = stat_in_r;
  assign stat_out_cnt = stat_out_r;
`endif

endmodule

// File: tb/tb_phase_pair_gen.sv
// Scoreboard bench for phase_pair_gen: directed stimulus pushes hand-computed tuples,
// a negedge monitor pops and compares on every output fire.
module tb_phase_pair_gen;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, phase_valid, phase_ready;
  logic [11:0] step;
  logic [14:0] in_phase, phase1, phase2;
  logic [7:0]  in_pass, phase_frac, phase_pass_data;
`ifdef PHASE_PAIR_STAT_EN
  logic [31:0] stat_in_cnt, stat_out_cnt;
`endif

  typedef struct packed {
    logic [14:0] p1;
    logic [14:0] p2;
    logic [7:0]  fr;
    logic [7:0]  pd;
  } tuple_t;

  tuple_t exp_q[$];
  tuple_t mon_e;
  int     total_cnt = 0;
  int     pass_cnt  = 0;

  always #5 clk = ~clk;

  phase_pair_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .step            (step),
    .in_phase        (in_phase),
    .in_pass         (in_pass),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .phase1          (phase1),
    .phase2          (phase2),
    .phase_frac      (phase_frac),
    .phase_pass_data (phase_pass_data),
    .phase_valid     (phase_valid),
    .phase_ready     (phase_ready)
`ifdef PHASE_PAIR_STAT_EN
    ,
    .stat_in_cnt     (stat_in_cnt),
    .stat_out_cnt    (stat_out_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] side(input logic [14:0] v);
    return v[7:0] ^ 8'hA5;
  endfunction

  task automatic expect_t(input logic [14:0] a, input logic [14:0] b, input logic [7:0] fr);
    tuple_t t;
    t.p1 = a; t.p2 = b; t.fr = fr; t.pd = side(b);
    exp_q.push_back(t);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [14:0] v);
    int   n;
    logic fired;
    n = 0;
    fired = 1'b0;
    in_valid = 1'b1;
    in_phase = v;
    in_pass  = side(v);
    while (!fired && n < 200) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!fired) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cyc(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  // Scoreboard monitor: compares each fired output tuple against the queue head
  always @(negedge clk) begin
    if (rst_n && phase_valid && phase_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {17'd0, phase2}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("phase1", {17'd0, phase1}, {17'd0, mon_e.p1});
        chk("phase2", {17'd0, phase2}, {17'd0, mon_e.p2});
        chk("phase_frac", {24'd0, phase_frac}, {24'd0, mon_e.fr});
        chk("pass_data", {24'd0, phase_pass_data}, {24'd0, mon_e.pd});
      end
      chk("ready_valid_excl", {31'd0, in_ready}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; phase_ready = 1'b0;
    step = 12'h000; in_phase = 15'd0; in_pass = 8'd0;
    #1;
    chk("rst_valid", {31'd0, phase_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_phase1", {17'd0, phase1}, 32'd0);
    chk("rst_phase2", {17'd0, phase2}, 32'd0);
    chk("rst_frac", {24'd0, phase_frac}, 32'd0);
    chk("rst_pass", {24'd0, phase_pass_data}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // step 0.5: each pair emitted twice
    step = 12'h080; phase_ready = 1'b1;
    expect_t(15'd10, 15'd20, 8'd0);   expect_t(15'd10, 15'd20, 8'd128);
    expect_t(15'd20, 15'd30, 8'd0);   expect_t(15'd20, 15'd30, 8'd128);
    send(15'd10); send(15'd20); send(15'd30);
    drain();
    cyc(3);
    chk("t1_stall_valid", {31'd0, phase_valid}, 32'd0);
    chk("t1_stall_ready", {31'd0, in_ready}, 32'd1);
`ifdef PHASE_PAIR_STAT_EN
    chk("t1_stat_in", stat_in_cnt, 32'd3);
    chk("t1_stat_out", stat_out_cnt, 32'd4);
`endif
    flush_pulse();

    // step 1.5
    step = 12'h180;
    expect_t(15'd10, 15'd20, 8'd0); expect_t(15'd20, 15'd30, 8'd128); expect_t(15'd40, 15'd50, 8'd0);
    for (int i = 1; i <= 5; i++) send(15'(i * 10));
    drain();
    cyc(2);
    chk("t2_idle_valid", {31'd0, phase_valid}, 32'd0);
    flush_pulse();

    // step 2.0
    step = 12'h200;
    expect_t(15'd10, 15'd20, 8'd0); expect_t(15'd30, 15'd40, 8'd0); expect_t(15'd50, 15'd60, 8'd0);
    for (int i = 1; i <= 6; i++) send(15'(i * 10));
    drain();
    flush_pulse();

    // backpressure: output must hold with no accumulator movement
    step = 12'h080; phase_ready = 1'b0;
    send(15'd10); send(15'd20);
    chk("t4_latency_valid", {31'd0, phase_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_p1", {17'd0, phase1}, 32'd10);
      chk("t4_hold_p2", {17'd0, phase2}, 32'd20);
      chk("t4_hold_frac", {24'd0, phase_frac}, 32'd0);
      chk("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    expect_t(15'd10, 15'd20, 8'd0);   expect_t(15'd10, 15'd20, 8'd128);
    expect_t(15'd20, 15'd30, 8'd0);   expect_t(15'd20, 15'd30, 8'd128);
    phase_ready = 1'b1;
    send(15'd30);
    drain();
    flush_pulse();

    // flush in RUN with acc=0x80
    phase_ready = 1'b0;
    send(15'd10); send(15'd20);
    expect_t(15'd10, 15'd20, 8'd0);
    phase_ready = 1'b1;
    cyc(1);
    phase_ready = 1'b0;
    chk("t5_frac_before_flush", {24'd0, phase_frac}, 32'd128);
    flush_pulse();
    chk("t5_flush_valid", {31'd0, phase_valid}, 32'd0);
    chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PHASE_PAIR_STAT_EN
    chk("t5_flush_stat_in", stat_in_cnt, 32'd0);
`endif
    expect_t(15'd100, 15'd200, 8'd0); expect_t(15'd100, 15'd200, 8'd128);
    phase_ready = 1'b1;
    send(15'd100); send(15'd200);
    drain();
    cyc(2);

    // step 0: same tuple repeats
    phase_ready = 1'b0; step = 12'h000;
    flush_pulse();
    send(15'd7); send(15'd9);
    for (int i = 0; i < 3; i++) expect_t(15'd7, 15'd9, 8'd0);
    phase_ready = 1'b1;
    cyc(3);
    phase_ready = 1'b0;
    chk("t6_left", exp_q.size(), 32'd0);
    chk("t6_still_valid", {31'd0, phase_valid}, 32'd1);
`ifdef PHASE_PAIR_STAT_EN
    chk("t6_stat_in", stat_in_cnt, 32'd2);
    chk("t6_stat_out", stat_out_cnt, 32'd3);
`endif

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("t7_valid", {31'd0, phase_valid}, 32'd0);
    chk("t7_phase1", {17'd0, phase1}, 32'd0);
    chk("t7_phase2", {17'd0, phase2}, 32'd0);
    chk("t7_frac", {24'd0, phase_frac}, 32'd0);
    chk("t7_pass", {24'd0, phase_pass_data}, 32'd0);
`ifdef PHASE_PAIR_STAT_EN
    chk("t7_stat_in", stat_in_cnt, 32'd0);
    chk("t7_stat_out", stat_out_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
